// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader: FSM state encoding, default
//   image magic byte, error codes and the header length field width.
package program_loader_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    MAGIC_S = 4'd1,
    LEN_LO  = 4'd2,
    LEN_HI  = 4'd3,
    DATA    = 4'd4,
    WRITE   = 4'd5,
    CSUM    = 4'd6,
    DONE    = 4'd7,
    ERR     = 4'd8
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'h52;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MAGIC = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CSUM  = 2'b11;

  // Width of the word-count field in the image header.
  localparam int LEN_WIDTH = 16;

  // States in which the loader consumes a byte from the stream.
  function automatic logic is_rx_state(input state_t s);
    return (s == MAGIC_S) || (s == LEN_LO) || (s == LEN_HI) ||
           (s == DATA)    || (s == CSUM);
  endfunction

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// byte_word_packer
//   Assembles four bytes into one little-endian 32-bit word. The first byte
//   of a word ends up in [7:0], the fourth in [31:24].
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clear       restart at lane 0 with an empty word
//     byte_valid  byte_in is taken this cycle
//     byte_in     data byte
//     word        assembled word (stable until the next taken byte)
//     word_full   this cycle's byte completes the word
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] lane_q;

  // Shift in from the top: after four bytes the first one sits in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd0;
      word   <= 32'd0;
    end else if (clear) begin
      lane_q <= 2'd0;
      word   <= 32'd0;
    end else if (byte_valid) begin
      lane_q <= lane_q + 2'd1;
      word   <= {byte_in, word[31:8]};
    end
  end

  assign word_full = byte_valid && (lane_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Streams a program image byte by byte into the instruction memory and
//   holds the core in program mode while doing so.
//   Image: MAGIC, word count (16 bit, low byte first), count*4 data bytes
//   (little-endian words) and, when PROGRAM_LOADER_CHECKSUM_EN is defined,
//   one trailing byte equal to the XOR of all data bytes.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load_req        pulse; starts a load from IDLE, DONE or ERR
//     rx_data/valid   byte stream in
//     rx_ready        byte accepted on an edge where rx_valid && rx_ready
//     pgm             program mode (loading or error)
//     prog_we/addr/wdata  one-cycle word write to program memory
//     busy, done, error, error_code  load status
//   Handshake: a byte transfers on every rising clk edge where rx_valid and
//   rx_ready are both high; the source holds rx_data stable until then.
//   Configuration macro: PROGRAM_LOADER_CHECKSUM_EN (trailer checksum).
//   INSTR_ADDR_WIDTH is expected to be below LEN_WIDTH.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         INSTR_ADDR_WIDTH = 8,
  parameter logic [7:0] MAGIC            = MAGIC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_req,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic                        prog_we,
  output logic [INSTR_ADDR_WIDTH-1:0] prog_addr,
  output logic [31:0]                 prog_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  error_code
);

  localparam int AW = INSTR_ADDR_WIDTH;

  // Memory capacity in words, widened by one bit so 2**AW itself fits.
  localparam logic [LEN_WIDTH:0] CAPACITY =
    {{(LEN_WIDTH-AW){1'b0}}, 1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic                 accept;
  logic                 load_start;
  logic [7:0]           len_lo_q;
  logic [LEN_WIDTH-1:0] len_word;
  logic                 len_bad;
  logic [AW-1:0]        last_addr_q;
  logic                 last_word;
  logic                 pk_clear;
  logic                 pk_valid;
  logic                 pk_full;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign accept     = rx_valid && rx_ready;
  assign load_start = load_req &&
                      ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign len_word   = {rx_data, len_lo_q};
  assign len_bad    = (len_word == '0) || ({1'b0, len_word} > CAPACITY);
  assign last_word  = (prog_addr == last_addr_q);

  // ---------------------------------------------------------------------
  // State register; rx_ready is registered from the next state so it is
  // a clean flop output and is low for the whole WRITE cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rx_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_ready <= is_rx_state(state_d);
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) state_d = MAGIC_S;
      end
      MAGIC_S: begin
        if (accept) state_d = (rx_data == MAGIC) ? LEN_LO : ERR;
      end
      LEN_LO: begin
        if (accept) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept) state_d = len_bad ? ERR : DATA;
      end
      DATA: begin
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        if (!last_word) begin
          state_d = DATA;
        end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    pgm     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    prog_we = 1'b0;
    case (state_q)
      MAGIC_S, LEN_LO, LEN_HI, DATA, CSUM: begin
        pgm  = 1'b1;
        busy = 1'b1;
      end
      WRITE: begin
        pgm     = 1'b1;
        busy    = 1'b1;
        prog_we = 1'b1;
      end
      DONE: done = 1'b1;
      ERR: begin
        pgm   = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Header, address and error-code datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_q    <= 8'd0;
      last_addr_q <= '0;
      prog_addr   <= '0;
      error_code  <= ERR_NONE;
    end else begin
      if (load_start) begin
        prog_addr  <= '0;
        error_code <= ERR_NONE;
      end
      if ((state_q == LEN_LO) && accept) len_lo_q <= rx_data;
      // Only a validated count is kept, so last_addr never exceeds 2**AW-1.
      if ((state_q == LEN_HI) && accept && !len_bad)
        last_addr_q <= AW'(len_word - LEN_WIDTH'(1));
      // The address advances after the strobe, never past the last word.
      if ((state_q == WRITE) && !last_word) prog_addr <= prog_addr + ADDR_ONE;
      if ((state_d == ERR) && (state_q != ERR)) begin
        case (state_q)
          MAGIC_S: error_code <= ERR_MAGIC;
          LEN_HI:  error_code <= ERR_LEN;
          default: error_code <= ERR_CSUM;
        endcase
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (load_start) begin
      csum_q <= 8'd0;
    end else if ((state_q == DATA) && accept) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------
  assign pk_clear = load_start;
  assign pk_valid = (state_q == DATA) && accept;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_in    (rx_data),
    .word       (prog_wdata),
    .word_full  (pk_full)
  );

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pgm;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  error_code;

  int checks;
  int failures;

  // Scoreboard: expected writes as {addr, data}.
  logic [39:0] exp_q[$];
  // Image under test and what the reference model predicts for it.
  logic [7:0]  img[$];
  logic [1:0]  exp_code;
  int          n_use;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pgm        (pgm),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .error_code (error_code)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (!rst && prog_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: got addr=%0h data=%08h, required no write",
                 prog_addr, prog_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({prog_addr, prog_wdata} !== e || rx_ready !== 1'b0) begin
          failures++;
          $display("FAIL write: got addr=%0h data=%08h rx_ready=%b, required addr=%0h data=%08h rx_ready=0",
                   prog_addr, prog_wdata, rx_ready, e[39:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Computes writes, final error code and number of bytes the loader
  // consumes, straight from the image format rules.
  task automatic run_model();
    int cnt;
    logic [7:0] x;
    x = 8'h00;
    exp_code = 2'b00;
    if (img[0] != 8'h52) begin
      exp_code = 2'b01;
      n_use = 1;
      return;
    end
    cnt = int'(img[1]) + 256 * int'(img[2]);
    if (cnt == 0 || cnt > 256) begin
      exp_code = 2'b10;
      n_use = 3;
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      logic [7:0] a;
      a = w[7:0];
      exp_q.push_back({a, img[6+4*w], img[5+4*w], img[4+4*w], img[3+4*w]});
      for (int k = 0; k < 4; k++) x ^= img[3+4*w+k];
    end
    n_use = 3 + 4 * cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (img[n_use] != x) exp_code = 2'b11;
    n_use++;
`endif
  endtask

  // Random image with the given word count; bad_csum corrupts the trailer.
  task automatic build_image(input int cnt, input bit bad_magic, input bit bad_csum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    img.delete();
    b = bad_magic ? 8'($urandom_range(255, 83)) : 8'h52;
    img.push_back(b);
    img.push_back(8'(cnt));
    img.push_back(8'(cnt >> 8));
    if (cnt >= 1 && cnt <= 256) begin
      for (int i = 0; i < 4 * cnt; i++) begin
        b = 8'($urandom_range(255));
        x ^= b;
        img.push_back(b);
      end
    end
    img.push_back(bad_csum ? (x ^ 8'($urandom_range(255, 1))) : x);
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    if ($urandom_range(99) < gap_pct) begin
      repeat ($urandom_range(3, 1)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(255));
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b, required 1 within 200 cycles", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic start_load(input string name);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++;
    if ({pgm, busy, done, error, error_code, rx_ready, prog_addr} !== {7'b1100001, 8'h00}) begin
      failures++;
      $display("FAIL %s_start: got pgm=%b busy=%b done=%b error=%b code=%b rx_ready=%b addr=%0h, required 1 1 0 0 00 1 0",
               name, pgm, busy, done, error, error_code, rx_ready, prog_addr);
    end
  endtask

  // Full load of img: model, drive, then check final status and scoreboard.
  task automatic do_load(input string name, input int gap_pct, input bit poke);
    logic exp_ok;
    start_load(name);
    run_model();
    for (int i = 0; i < n_use; i++) begin
      if (poke && i == 5) begin
        // load_req mid-load must be ignored
        rx_valid = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
      end
      send_byte(img[i], gap_pct);
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_ok = (exp_code == 2'b00);
    checks++;
    if ({done, error, error_code, pgm, busy, rx_ready} !== {exp_ok, !exp_ok, exp_code, !exp_ok, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_status: got done=%b error=%b code=%b pgm=%b busy=%b rx_ready=%b, required done=%b error=%b code=%b pgm=%b busy=0 rx_ready=0",
               name, done, error, error_code, pgm, busy, rx_ready, exp_ok, !exp_ok, exp_code, !exp_ok);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes: got %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, pgm, prog_we, busy, done, error, error_code, prog_addr, prog_wdata} !== 48'd0) begin
      failures++;
      $display("FAIL reset: got rx_ready=%b pgm=%b we=%b busy=%b done=%b error=%b code=%b addr=%0h wdata=%08h, required all zero",
               rx_ready, pgm, prog_we, busy, done, error, error_code, prog_addr, prog_wdata);
    end
  endtask

  task automatic test_clean(input int gap_pct, input string name);
    logic [7:0] bytes [11];
    bytes = '{8'h52, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    img.delete();
    foreach (bytes[i]) img.push_back(bytes[i]);
    img.push_back(8'h2A);  // XOR of the eight data bytes
    do_load(name, gap_pct, 1'b0);
  endtask

  task automatic test_bad_magic();
    img.delete();
    img.push_back(8'h00);
    do_load("bad_magic", 0, 1'b0);
  endtask

  task automatic test_bad_len();
    build_image(257, 1'b0, 1'b0);
    do_load("bad_len_257", 20, 1'b0);
    build_image(0, 1'b0, 1'b0);
    do_load("bad_len_0", 0, 1'b0);
  endtask

  task automatic test_full_capacity();
    build_image(256, 1'b0, 1'b0);
    do_load("full_256", 0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    test_clean(0, "pre_reset");
    build_image(3, 1'b0, 1'b0);
    start_load("mid_reset");
    for (int i = 0; i < 5; i++) send_byte(img[i], 0);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, pgm, prog_we, busy, done, error, error_code, prog_addr, prog_wdata} !== 48'd0) begin
      failures++;
      $display("FAIL mid_reset: got rx_ready=%b pgm=%b we=%b busy=%b done=%b error=%b code=%b addr=%0h wdata=%08h, required all zero",
               rx_ready, pgm, prog_we, busy, done, error, error_code, prog_addr, prog_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_clean(30, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int sel;
      int cnt;
      sel = $urandom_range(9);
      cnt = $urandom_range(6, 1);
      if (sel == 0)      build_image(cnt, 1'b1, 1'b0);
      else if (sel == 1) build_image($urandom_range(400, 257), 1'b0, 1'b0);
      else if (sel == 2) build_image(cnt, 1'b0, 1'b1);
      else               build_image(cnt, 1'b0, 1'b0);
      do_load($sformatf("rand%0d", t), $urandom_range(70), sel[0]);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    test_clean(0, "csum_ok");
    test_clean(0, "csum_prep");
    img[11] = 8'h2B;
    do_load("csum_bad", 0, 1'b0);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_clean(0, "clean");
    test_bad_magic();
    test_clean(50, "backpressure");
    test_bad_len();
    test_full_capacity();
    test_reset_mid_load();
    test_random();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
